// File: rtl/threshold_monitor_pkg.sv
// ---------------------------------------------------------------------------
// threshold_monitor_pkg
// Shared definitions for the threshold monitor slice: the 2-bit zone
// encoding used by the classifier and the zone state machine, plus the
// default parameter values of the top level.
// ---------------------------------------------------------------------------
package threshold_monitor_pkg;

  // Zone encoding; 2'b11 is never produced.
  typedef enum logic [1:0] {
    ZONE_BELOW  = 2'b00,
    ZONE_INSIDE = 2'b01,
    ZONE_ABOVE  = 2'b10
  } zone_t;

  localparam int DEBOUNCE_DEFAULT = 3;
  localparam int CNT_W_DEFAULT    = 8;

endpackage : threshold_monitor_pkg

// File: rtl/threshold_classify.sv
// ---------------------------------------------------------------------------
// threshold_classify
// Purely combinational classifier: compares a 4-bit unsigned sample against
// inclusive low/high thresholds and reports BELOW, INSIDE or ABOVE.
// An inverted threshold pair (thr_lo > thr_hi) is flagged and forces INSIDE.
//
// Ports:
//   sample   in   4  unsigned sample
//   thr_lo   in   4  low threshold, inclusive edge of INSIDE
//   thr_hi   in   4  high threshold, inclusive edge of INSIDE
//   cls      out  2  zone class of the sample (zone_t)
//   cfg_bad  out  1  thresholds inverted
// ---------------------------------------------------------------------------
module threshold_classify
  import threshold_monitor_pkg::*;
(
  input  logic [3:0] sample,
  input  logic [3:0] thr_lo,
  input  logic [3:0] thr_hi,
  output zone_t      cls,
  output logic       cfg_bad
);

  // Two magnitude compares plus the inverted-threshold override.
  always_comb begin
    cls     = ZONE_INSIDE;
    cfg_bad = (thr_lo > thr_hi);
    if (cfg_bad) begin
      cls = ZONE_INSIDE;
    end else if (sample > thr_hi) begin
      cls = ZONE_ABOVE;
    end else if (sample < thr_lo) begin
      cls = ZONE_BELOW;
    end else begin
      cls = ZONE_INSIDE;
    end
  end

endmodule : threshold_classify

// File: rtl/threshold_monitor.sv
// ---------------------------------------------------------------------------
// threshold_monitor
// Classifies a stream of 4-bit samples against programmable thresholds and
// debounces zone changes: a new zone is adopted only after DEBOUNCE
// consecutive agreeing valid samples (idle cycles do not break the run).
// Produces a registered zone, a level alarm (zone != INSIDE), a one-cycle
// change pulse, a misconfiguration flag and a saturating sample counter.
//
// Optional feature (macro MINMAX_TRACK_EN): running min/max of accepted
// samples with a synchronous clear input.
//
// Ports:
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous reset, active-high
//   sample_valid  in   1      sample qualifier
//   sample        in   4      unsigned sample
//   thr_lo        in   4      low threshold (inclusive)
//   thr_hi        in   4      high threshold (inclusive)
//   zone          out  2      00 BELOW, 01 INSIDE, 10 ABOVE
//   zone_change   out  1      pulse in the cycle zone shows a new value
//   alarm         out  1      zone != INSIDE
//   cfg_err       out  1      thr_lo > thr_hi (registered)
//   sample_cnt    out  CNT_W  accepted samples, saturating
//   minmax_clr    in   1      (MINMAX_TRACK_EN) reload min/max start values
//   min_val       out  4      (MINMAX_TRACK_EN) smallest accepted sample
//   max_val       out  4      (MINMAX_TRACK_EN) largest accepted sample
// ---------------------------------------------------------------------------
module threshold_monitor
  import threshold_monitor_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [3:0]       sample,
  input  logic [3:0]       thr_lo,
  input  logic [3:0]       thr_hi,
  output logic [1:0]       zone,
  output logic             zone_change,
  output logic             alarm,
  output logic             cfg_err,
`ifdef MINMAX_TRACK_EN
  input  logic             minmax_clr,
  output logic [3:0]       min_val,
  output logic [3:0]       max_val,
`endif
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [3:0]       DEB_LIM = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  zone_t            cls_s;
  logic             cfg_bad_s;

  zone_t            zone_r;
  zone_t            zone_nxt_s;
  zone_t            cand_r;
  zone_t            cand_nxt_s;
  logic [3:0]       deb_cnt_r;
  logic [3:0]       deb_nxt_s;
  logic [3:0]       deb_inc_s;
  logic             upd_s;
  logic             zone_change_r;
  logic             alarm_r;
  logic             cfg_err_r;
  logic [CNT_W-1:0] sample_cnt_r;

  threshold_classify u_classify (
    .sample  (sample),
    .thr_lo  (thr_lo),
    .thr_hi  (thr_hi),
    .cls     (cls_s),
    .cfg_bad (cfg_bad_s)
  );

  assign deb_inc_s = deb_cnt_r + 4'd1;

  // Debounce next-state: candidate tracking and zone adoption.
  always_comb begin
    zone_nxt_s = zone_r;
    cand_nxt_s = cand_r;
    deb_nxt_s  = deb_cnt_r;
    upd_s      = 1'b0;
    if (sample_valid) begin
      if (cls_s == zone_r) begin
        // Sample agrees with the current zone: the run toward the
        // candidate is broken, but the candidate itself is remembered.
        deb_nxt_s = 4'd0;
      end else if (cls_s == cand_r) begin
        if (deb_inc_s == DEB_LIM) begin
          zone_nxt_s = cls_s;
          deb_nxt_s  = 4'd0;
          upd_s      = 1'b1;
        end else begin
          deb_nxt_s = deb_inc_s;
        end
      end else begin
        // New candidate; with a debounce length of one it wins at once.
        cand_nxt_s = cls_s;
        if (DEB_LIM == 4'd1) begin
          zone_nxt_s = cls_s;
          deb_nxt_s  = 4'd0;
          upd_s      = 1'b1;
        end else begin
          deb_nxt_s = 4'd1;
        end
      end
    end else begin
      zone_nxt_s = zone_r;
      cand_nxt_s = cand_r;
      deb_nxt_s  = deb_cnt_r;
      upd_s      = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      zone_r        <= ZONE_INSIDE;
      cand_r        <= ZONE_INSIDE;
      deb_cnt_r     <= 4'd0;
      zone_change_r <= 1'b0;
      alarm_r       <= 1'b0;
      cfg_err_r     <= 1'b0;
      sample_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      zone_r        <= zone_nxt_s;
      cand_r        <= cand_nxt_s;
      deb_cnt_r     <= deb_nxt_s;
      zone_change_r <= upd_s;
      alarm_r       <= (zone_nxt_s != ZONE_INSIDE);
      cfg_err_r     <= cfg_bad_s;
      if (sample_valid && (sample_cnt_r != CNT_MAX)) begin
        sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      end
    end
  end

  assign zone        = zone_r;
  assign zone_change = zone_change_r;
  assign alarm       = alarm_r;
  assign cfg_err     = cfg_err_r;
  assign sample_cnt  = sample_cnt_r;

`ifdef MINMAX_TRACK_EN
  logic [3:0] min_r;
  logic [3:0] max_r;
  logic [3:0] min_base_s;
  logic [3:0] max_base_s;
  logic [3:0] min_nxt_s;
  logic [3:0] max_nxt_s;

  // Clear first, then fold in a coincident valid sample.
  always_comb begin
    min_base_s = min_r;
    max_base_s = max_r;
    if (minmax_clr) begin
      min_base_s = 4'hF;
      max_base_s = 4'h0;
    end else begin
      min_base_s = min_r;
      max_base_s = max_r;
    end
    min_nxt_s = min_base_s;
    max_nxt_s = max_base_s;
    if (sample_valid) begin
      min_nxt_s = (sample < min_base_s) ? sample : min_base_s;
      max_nxt_s = (sample > max_base_s) ? sample : max_base_s;
    end else begin
      min_nxt_s = min_base_s;
      max_nxt_s = max_base_s;
    end
  end

  // Min/max registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_r <= 4'hF;
      max_r <= 4'h0;
    end else begin
      min_r <= min_nxt_s;
      max_r <= max_nxt_s;
    end
  end

  assign min_val = min_r;
  assign max_val = max_r;
`endif

endmodule : threshold_monitor

// File: tb/tb_threshold_monitor.sv
// ---------------------------------------------------------------------------
// tb_threshold_monitor
// Directed-vector bench with a scoreboard: each driven cycle pushes its
// hand-computed expected outputs (tagged with the cycle they must appear in)
// and an independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_threshold_monitor;

  localparam logic [1:0] Z_BE = 2'b00;
  localparam logic [1:0] Z_IN = 2'b01;
  localparam logic [1:0] Z_AB = 2'b10;

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  zone;
    logic        chg;
    logic        alarm;
    logic        cfg;
    logic [7:0]  cnt;
    logic        mmchk;
    logic [3:0]  mn;
    logic [3:0]  mx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [3:0] sample;
  logic [3:0] thr_lo;
  logic [3:0] thr_hi;
  logic [1:0] zone;
  logic       zone_change;
  logic       alarm;
  logic       cfg_err;
  logic [7:0] sample_cnt;
`ifdef MINMAX_TRACK_EN
  logic       minmax_clr;
  logic [3:0] min_val;
  logic [3:0] max_val;
`endif

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic [7:0]  m_cnt = 8'd0;
  logic [3:0]  nlo = 4'd4;
  logic [3:0]  nhi = 4'd10;

  threshold_monitor #(.DEBOUNCE(3), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .thr_lo       (thr_lo),
    .thr_hi       (thr_hi),
    .zone         (zone),
    .zone_change  (zone_change),
    .alarm        (alarm),
    .cfg_err      (cfg_err),
`ifdef MINMAX_TRACK_EN
    .minmax_clr   (minmax_clr),
    .min_val      (min_val),
    .max_val      (max_val),
`endif
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle and push the outputs expected after its clock edge.
  task automatic step(input bit r, input bit v, input logic [3:0] s,
                      input logic [1:0] ez, input bit ech,
                      input bit clr, input bit mmchk,
                      input logic [3:0] emn, input logic [3:0] emx);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    sample_valid = v;
    sample       = s;
    thr_lo       = nlo;
    thr_hi       = nhi;
`ifdef MINMAX_TRACK_EN
    minmax_clr   = clr;
`endif
    if (r) m_cnt = 8'd0;
    else if (v && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.cyc   = cyc + 1;
    e.zone  = ez;
    e.chg   = ech;
    e.alarm = (ez != Z_IN);
    e.cfg   = r ? 1'b0 : (nlo > nhi);
    e.cnt   = m_cnt;
    e.mmchk = mmchk & ~clr | mmchk;
    e.mn    = emn;
    e.mx    = emx;
    sb_q.push_back(e);
  endtask

  task automatic st(input bit v, input logic [3:0] s, input logic [1:0] ez, input bit ech);
    step(1'b0, v, s, ez, ech, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  // Monitor: compare every expectation due in the cycle just completed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        checks++;
        if ({zone, zone_change, alarm, cfg_err, sample_cnt} !==
            {e.zone, e.chg, e.alarm, e.cfg, e.cnt}) begin
          errors++;
          $display("FAIL outputs cyc%0d: got zone=%b chg=%b alarm=%b cfg=%b cnt=%0d, want zone=%b chg=%b alarm=%b cfg=%b cnt=%0d",
                   cyc, zone, zone_change, alarm, cfg_err, sample_cnt,
                   e.zone, e.chg, e.alarm, e.cfg, e.cnt);
        end
`ifdef MINMAX_TRACK_EN
        if (e.mmchk) begin
          checks++;
          if ({min_val, max_val} !== {e.mn, e.mx}) begin
            errors++;
            $display("FAIL minmax cyc%0d: got min=%0d max=%0d, want min=%0d max=%0d",
                     cyc, min_val, max_val, e.mn, e.mx);
          end
        end
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample = 4'd0; thr_lo = 4'd4; thr_hi = 4'd10;
`ifdef MINMAX_TRACK_EN
    minmax_clr = 1'b0;
`endif
    // Reset then idle.
    step(1'b1, 1'b0, 4'd0, Z_IN, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0);
    step(1'b1, 1'b0, 4'd0, Z_IN, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0);
    st(1'b0, 4'd0, Z_IN, 1'b0);
    // Debounced rise: zone moves only after the third sample; single pulse.
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_AB, 1'b1);
    st(1'b0, 4'd0,  Z_AB, 1'b0);
    // Back inside.
    st(1'b1, 4'd7, Z_AB, 1'b0);
    st(1'b1, 4'd7, Z_AB, 1'b0);
    st(1'b1, 4'd7, Z_IN, 1'b1);
    // Glitch rejection, then one more agreeing sample.
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd7,  Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_AB, 1'b1);
    // Upper boundary is INSIDE.
    st(1'b1, 4'd10, Z_AB, 1'b0);
    st(1'b1, 4'd10, Z_AB, 1'b0);
    st(1'b1, 4'd10, Z_IN, 1'b1);
    // Rise again, then jump directly ABOVE -> BELOW.
    for (int i = 0; i < 2; i++) st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_AB, 1'b1);
    st(1'b1, 4'd3, Z_AB, 1'b0);
    st(1'b1, 4'd3, Z_AB, 1'b0);
    st(1'b1, 4'd3, Z_BE, 1'b1);
    st(1'b0, 4'd3, Z_BE, 1'b0);
    // Lower boundary is INSIDE.
    st(1'b1, 4'd4, Z_BE, 1'b0);
    st(1'b1, 4'd4, Z_BE, 1'b0);
    st(1'b1, 4'd4, Z_IN, 1'b1);
    // Valid gaps do not break the run.
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b0, 4'd0,  Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b0, 4'd0,  Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_AB, 1'b1);
    // Inverted thresholds: cfg_err, extremes classify INSIDE.
    nlo = 4'd9; nhi = 4'd5;
    st(1'b1, 4'd0,  Z_AB, 1'b0);
    st(1'b1, 4'd15, Z_AB, 1'b0);
    st(1'b1, 4'd0,  Z_IN, 1'b1);
    nlo = 4'd4; nhi = 4'd10;
    st(1'b0, 4'd0, Z_IN, 1'b0);
    // Reset mid-debounce discards the partial count.
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    step(1'b1, 1'b0, 4'd0, Z_IN, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_IN, 1'b0);
    st(1'b1, 4'd12, Z_AB, 1'b1);
    // Counter saturation.
    for (int i = 0; i < 300; i++) st(1'b1, 4'd12, Z_AB, 1'b0);
    // Min/max tracking with clear coinciding with the first sample.
    step(1'b0, 1'b1, 4'd5,  Z_AB, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5);
    step(1'b0, 1'b1, 4'd2,  Z_AB, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5);
    step(1'b0, 1'b1, 4'd14, Z_AB, 1'b0, 1'b0, 1'b1, 4'd2, 4'd14);
    st(1'b0, 4'd0, Z_AB, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_threshold_monitor
